axi_req_arbiter: RTL and testbench
==================================

Name: axi_req_arbiter

Overview:
- Shares one AXI4-Full master port among NUM_REQ single-beat register requesters, e.g. the cosim BFM path and an on-chip sequencer driving the SPI AXI controller.
- Grants round-robin and runs exactly one transaction at a time: AW+W then B for writes, AR then R for reads.
- Returns the response only to the requester that was granted.
- Sits between the requesters and the SPI AXI controller's AXI4-Full slave port.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
AXI_WIDTH_ADDR, 32, address width
AXI_WIDTH_DATA, 32, data width (32 or 64)

Ports:
aclk  input  1  clock
areset  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester command valid
req_ready  output  NUM_REQ  one-hot command accept pulse
req_write  input  NUM_REQ  1=write, 0=read, per requester
req_addr  input  NUM_REQ*AXI_WIDTH_ADDR  packed addresses, requester i at slice i
req_wdata  input  NUM_REQ*AXI_WIDTH_DATA  packed write data
req_wstrb  input  NUM_REQ*AXI_WIDTH_DATA/8  packed byte strobes
rsp_valid  output  NUM_REQ  one-hot response pulse
rsp_rdata  output  AXI_WIDTH_DATA  read data, valid with rsp_valid
rsp_resp  output  2  BRESP/RRESP, valid with rsp_valid
busy  output  1  high whenever state is not IDLE
m_axi_awaddr  output  AXI_WIDTH_ADDR  write address
m_axi_awvalid  output  1  write address valid
m_axi_awready  input  1  write address ready
m_axi_wdata  output  AXI_WIDTH_DATA  write data
m_axi_wstrb  output  AXI_WIDTH_DATA/8  write strobes
m_axi_wlast  output  1  constant 1
m_axi_wvalid  output  1  write data valid
m_axi_wready  input  1  write data ready
m_axi_bresp  input  2  write response
m_axi_bvalid  input  1  write response valid
m_axi_bready  output  1  write response ready
m_axi_araddr  output  AXI_WIDTH_ADDR  read address
m_axi_arvalid  output  1  read address valid
m_axi_arready  input  1  read address ready
m_axi_rdata  input  AXI_WIDTH_DATA  read data
m_axi_rresp  input  2  read response
m_axi_rlast  input  1  read last
m_axi_rvalid  input  1  read data valid
m_axi_rready  output  1  read data ready
m_axi_axlen  output  8  constant 0, drives both AWLEN and ARLEN
m_axi_axsize  output  3  constant log2(AXI_WIDTH_DATA/8), drives AWSIZE and ARSIZE
m_axi_axburst  output  2  constant 2'b01 (INCR), drives AWBURST and ARBURST

Behaviour:
- Reset, sampled on aclk when areset=1: state IDLE, rr pointer=0; all valids/readies/rsp_valid/busy=0; address/data/rsp registers=0. Reset mid-transaction abandons it immediately; no response is produced.
- IDLE: if any req_valid, select the first set bit at or after rr pointer, wrapping modulo NUM_REQ.
  - Same edge: pulse req_ready[g]=1 for one cycle and latch write/addr/wdata/wstrb.
  - rr pointer <= g+1, wrapping to 0 after NUM_REQ-1.
  - Go to WR_ADDR or RD_ADDR.
- WR_ADDR: awvalid=1 and wvalid=1, asserted together from the cycle after grant.
  - Each valid drops independently on its own handshake.
  - When both handshakes are done (same or different cycles), go to WR_RESP.
- WR_RESP: bready=1. On bvalid, latch bresp and go to RESP.
- RD_ADDR: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, latch rdata/rresp and go to RESP.
  - If rlast=0 on that beat, force rresp to 2'b10 (SLVERR).
- RESP: rsp_valid[g]=1 for exactly one cycle, then IDLE. rsp_rdata is 0 for writes.
- Valid rules: awvalid/wvalid/arvalid are never deasserted before their ready. Address and data stay stable while valid.
- Latency, zero-wait slave:
  - write: req_ready to rsp_valid = 4 cycles (AW/W, B, RESP).
  - read: same 4 cycles (AR, R, RESP).
  - Minimum turnaround between grants: 1 IDLE cycle.
- A requester holding req_valid continuously is served once per rotation, so there is no starvation.
- rsp_* never pulses for a non-granted requester.
- req_* inputs are ignored outside IDLE.

Test Plan:
- Single write, requester 0: addr=0x10, wdata=0xA5A5_0001, wstrb=0xF, zero-wait slave → AW and W in the same cycle; rsp_valid=2'b01 four cycles after req_ready; rsp_resp=0.
- Read, requester 1: slave returns 0xDEAD_BEEF with rlast=1 after 3 wait cycles → rsp_valid=2'b10, rsp_rdata=0xDEAD_BEEF, rsp_resp=0.
- Both requesters valid continuously, 6 transactions → grants alternate 0,1,0,1,0,1.
- Write with awready held low 2 cycles and wready low 5 cycles → wvalid stays high after the AW handshake; bready rises only after both handshakes complete.
- Read beat with rlast=0 → rsp_resp=2'b10; slave BRESP=2'b11 on a write → rsp_resp=2'b11.
- areset asserted in WR_RESP → next cycle state IDLE, all outputs 0, no rsp_valid; a new request is served afterwards starting from requester 0.

Source files
------------

// File: rtl/axi_req_arbiter_if.sv
// AXI4-Full master-side bus used by axi_req_arbiter. Single-beat only, so
// AxLEN/AxSIZE/AxBURST are shared between the write and read address channels.
interface axi_req_arbiter_if #(
  parameter int AXI_WIDTH_ADDR = 32,
  parameter int AXI_WIDTH_DATA = 32
);

  // write address channel
  logic [AXI_WIDTH_ADDR-1:0]   awaddr;
  logic                        awvalid;
  logic                        awready;

  // write data channel
  logic [AXI_WIDTH_DATA-1:0]   wdata;
  logic [AXI_WIDTH_DATA/8-1:0] wstrb;
  logic                        wlast;
  logic                        wvalid;
  logic                        wready;

  // write response channel
  logic [1:0]                  bresp;
  logic                        bvalid;
  logic                        bready;

  // read address channel
  logic [AXI_WIDTH_ADDR-1:0]   araddr;
  logic                        arvalid;
  logic                        arready;

  // read data channel
  logic [AXI_WIDTH_DATA-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rlast;
  logic                        rvalid;
  logic                        rready;

  // burst attributes shared by AW and AR
  logic [7:0]                  axlen;
  logic [2:0]                  axsize;
  logic [1:0]                  axburst;

  modport master (
    output awaddr, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    output araddr, arvalid,
    output rready,
    output axlen, axsize, axburst,
    input  awready, wready,
    input  bresp, bvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awaddr, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    input  araddr, arvalid,
    input  rready,
    input  axlen, axsize, axburst,
    output awready, wready,
    output bresp, bvalid,
    output arready,
    output rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/axi_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Full master port among NUM_REQ
// single-beat register requesters. One transaction is in flight at a time;
// the response is routed back only to the requester that was granted.
module axi_req_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int AXI_WIDTH_ADDR = 32,
  parameter int AXI_WIDTH_DATA = 32
) (
  input  logic                                  aclk,
  input  logic                                  areset,

  // requester command side
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0]                    req_write,
  input  logic [NUM_REQ*AXI_WIDTH_ADDR-1:0]     req_addr,
  input  logic [NUM_REQ*AXI_WIDTH_DATA-1:0]     req_wdata,
  input  logic [NUM_REQ*AXI_WIDTH_DATA/8-1:0]   req_wstrb,

  // requester response side
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [AXI_WIDTH_DATA-1:0]             rsp_rdata,
  output logic [1:0]                            rsp_resp,
  output logic                                  busy,

  // shared AXI4-Full master port
  axi_req_arbiter_if.master                     m_axi
);

  localparam int          STRB_W    = AXI_WIDTH_DATA / 8;
  localparam int          IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NUM_REQ_U = NUM_REQ;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [2:0]  AXSIZE    = 3'($clog2(STRB_W));
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RESP
  } state_t;

  state_t                    state;
  state_t                    state_next;

  logic [IDX_W-1:0]          rr_ptr;
  logic [IDX_W-1:0]          grant_idx;
  logic                      grant_found;
  logic [IDX_W-1:0]          grant_q;

  logic [AXI_WIDTH_ADDR-1:0] addr_q;
  logic [AXI_WIDTH_DATA-1:0] wdata_q;
  logic [STRB_W-1:0]         wstrb_q;
  logic [AXI_WIDTH_DATA-1:0] rdata_q;
  logic [1:0]                resp_q;

  // AW and W complete independently; these remember which one is done
  logic                      aw_done;
  logic                      w_done;

  logic                      aw_hs;
  logic                      w_hs;
  logic                      b_hs;
  logic                      r_hs;

  assign aw_hs = m_axi.awvalid && m_axi.awready;
  assign w_hs  = m_axi.wvalid  && m_axi.wready;
  assign b_hs  = m_axi.bvalid  && m_axi.bready;
  assign r_hs  = m_axi.rvalid  && m_axi.rready;

  // Address/data come straight from the latched command, so they are
  // stable for as long as the corresponding valid is held.
  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wlast   = 1'b1;
  assign m_axi.axlen   = 8'd0;
  assign m_axi.axsize  = AXSIZE;
  assign m_axi.axburst = 2'b01;

  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_REQ_U; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= NUM_REQ_U) begin
        idx = idx - NUM_REQ_U;
      end
      if (!grant_found && req_valid[IDX_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(idx);
      end
    end
  end

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next    = state;
    req_ready     = '0;
    rsp_valid     = '0;
    busy          = 1'b0;
    m_axi.awvalid = 1'b0;
    m_axi.wvalid  = 1'b0;
    m_axi.bready  = 1'b0;
    m_axi.arvalid = 1'b0;
    m_axi.rready  = 1'b0;

    case (state)
      IDLE: begin
        if (grant_found) begin
          // accept pulse is suppressed while reset is being applied
          req_ready[grant_idx] = !areset;
          state_next = req_write[grant_idx] ? WR_ADDR : RD_ADDR;
        end
      end

      WR_ADDR: begin
        busy          = 1'b1;
        m_axi.awvalid = !aw_done;
        m_axi.wvalid  = !w_done;
        if ((aw_done || m_axi.awready) && (w_done || m_axi.wready)) begin
          state_next = WR_RESP;
        end
      end

      WR_RESP: begin
        busy         = 1'b1;
        m_axi.bready = 1'b1;
        if (m_axi.bvalid) begin
          state_next = RESP;
        end
      end

      RD_ADDR: begin
        busy          = 1'b1;
        m_axi.arvalid = 1'b1;
        if (m_axi.arready) begin
          state_next = RD_DATA;
        end
      end

      RD_DATA: begin
        busy         = 1'b1;
        m_axi.rready = 1'b1;
        if (m_axi.rvalid) begin
          state_next = RESP;
        end
      end

      RESP: begin
        busy                = 1'b1;
        rsp_valid[grant_q]  = 1'b1;
        state_next          = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Command latch, round-robin pointer, channel progress and response capture.
  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr  <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            grant_q <= grant_idx;
            addr_q  <= req_addr[grant_idx*AXI_WIDTH_ADDR +: AXI_WIDTH_ADDR];
            wdata_q <= req_wdata[grant_idx*AXI_WIDTH_DATA +: AXI_WIDTH_DATA];
            wstrb_q <= req_wstrb[grant_idx*STRB_W +: STRB_W];
            rr_ptr  <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            rdata_q <= '0;
            resp_q  <= '0;
          end
        end

        WR_ADDR: begin
          if (aw_hs) begin
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            w_done <= 1'b1;
          end
        end

        WR_RESP: begin
          if (b_hs) begin
            resp_q <= m_axi.bresp;
          end
        end

        RD_DATA: begin
          if (r_hs) begin
            rdata_q <= m_axi.rdata;
            // a single-beat read must end on its only beat
            resp_q  <= m_axi.rlast ? m_axi.rresp : RESP_SLVERR;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_req_arbiter.sv
// Directed bench for axi_req_arbiter: two requesters, a configurable-wait
// AXI slave model, and one task per scenario.
module tb_axi_req_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // slave model configuration
  int unsigned aw_wait = 0;
  int unsigned w_wait  = 0;
  int unsigned b_wait  = 0;
  int unsigned ar_wait = 0;
  int unsigned r_wait  = 0;
  logic [1:0]  s_bresp = 2'b00;
  logic [DW-1:0] s_rdata = '0;
  logic [1:0]  s_rresp = 2'b00;
  logic        s_rlast = 1'b1;

  int unsigned aw_cnt = 0;
  int unsigned w_cnt  = 0;
  int unsigned b_cnt  = 0;
  int unsigned ar_cnt = 0;
  int unsigned r_cnt  = 0;

  axi_req_arbiter_if #(.AXI_WIDTH_ADDR(AW), .AXI_WIDTH_DATA(DW)) m_axi ();

  axi_req_arbiter #(
    .NUM_REQ        (N),
    .AXI_WIDTH_ADDR (AW),
    .AXI_WIDTH_DATA (DW)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .busy      (busy),
    .m_axi     (m_axi)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Slave: each ready/valid rises after the configured number of cycles
  // that the DUT has been waiting on that channel.
  always @(negedge aclk) begin
    if (m_axi.awvalid) begin m_axi.awready = (aw_cnt >= aw_wait); aw_cnt++; end
    else begin m_axi.awready = 1'b0; aw_cnt = 0; end
    if (m_axi.wvalid) begin m_axi.wready = (w_cnt >= w_wait); w_cnt++; end
    else begin m_axi.wready = 1'b0; w_cnt = 0; end
    if (m_axi.bready) begin m_axi.bvalid = (b_cnt >= b_wait); b_cnt++; end
    else begin m_axi.bvalid = 1'b0; b_cnt = 0; end
    if (m_axi.arvalid) begin m_axi.arready = (ar_cnt >= ar_wait); ar_cnt++; end
    else begin m_axi.arready = 1'b0; ar_cnt = 0; end
    if (m_axi.rready) begin m_axi.rvalid = (r_cnt >= r_wait); r_cnt++; end
    else begin m_axi.rvalid = 1'b0; r_cnt = 0; end
    m_axi.bresp = s_bresp;
    m_axi.rdata = s_rdata;
    m_axi.rresp = s_rresp;
    m_axi.rlast = s_rlast;
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_write[i]          = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_wstrb[i*SW +: SW] = s;
    req_valid[i]          = 1'b1;
  endtask

  // Returns in the cycle where req_ready is seen (or after the bound).
  task automatic wait_grant();
    for (int i = 0; i < 50; i++) begin
      #1;
      if (req_ready !== '0) return;
      @(posedge aclk);
    end
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 60; i++) begin
      if (rsp_valid !== '0) return;
      tick();
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) tick();
    n_tests++; if ({busy, req_ready, rsp_valid} !== 5'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b expected 00000", {busy, req_ready, rsp_valid}); end
    n_tests++; if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready} !== 5'b0) begin n_fail++;
      $display("FAIL reset_axi: got %b expected 00000",
               {m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready}); end
    n_tests++; if ({rsp_rdata, rsp_resp, m_axi.awaddr} !== '0) begin n_fail++;
      $display("FAIL reset_regs: got %h/%h/%h expected 0", rsp_rdata, rsp_resp, m_axi.awaddr); end
    n_tests++; if ({m_axi.wlast, m_axi.axlen, m_axi.axsize, m_axi.axburst} !== {1'b1, 8'd0, 3'd2, 2'b01}) begin n_fail++;
      $display("FAIL const_attrs: got %b/%h/%0d/%b expected 1/00/2/01",
               m_axi.wlast, m_axi.axlen, m_axi.axsize, m_axi.axburst); end
    areset = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    int t0;
    set_req(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF);
    wait_grant();
    n_tests++; if (req_ready !== 2'b01) begin n_fail++;
      $display("FAIL wr_grant: got %b expected 01", req_ready); end
    t0 = cyc;
    tick();
    req_valid = '0;
    n_tests++; if ({m_axi.awvalid, m_axi.wvalid} !== 2'b11) begin n_fail++;
      $display("FAIL wr_aw_w_together: got %b expected 11", {m_axi.awvalid, m_axi.wvalid}); end
    n_tests++; if ({m_axi.awaddr, m_axi.wdata, m_axi.wstrb} !== {32'h10, 32'hA5A5_0001, 4'hF}) begin n_fail++;
      $display("FAIL wr_payload: got %h %h %h expected 10 a5a50001 f", m_axi.awaddr, m_axi.wdata, m_axi.wstrb); end
    tick();
    n_tests++; if ({m_axi.awvalid, m_axi.wvalid, m_axi.bready} !== 3'b001) begin n_fail++;
      $display("FAIL wr_bphase: got %b expected 001", {m_axi.awvalid, m_axi.wvalid, m_axi.bready}); end
    wait_rsp();
    n_tests++; if (rsp_valid !== 2'b01) begin n_fail++;
      $display("FAIL wr_rsp_valid: got %b expected 01", rsp_valid); end
    // req_ready cycle is the first of four; rsp_valid lands in the fourth
    n_tests++; if (cyc - t0 !== 3) begin n_fail++;
      $display("FAIL wr_latency: got %0d expected 3", cyc - t0); end
    n_tests++; if ({rsp_resp, rsp_rdata} !== 34'd0) begin n_fail++;
      $display("FAIL wr_rsp_data: got %b/%h expected 00/0", rsp_resp, rsp_rdata); end
    tick();
    n_tests++; if ({rsp_valid, busy} !== 3'b000) begin n_fail++;
      $display("FAIL wr_rsp_pulse: got %b expected 000", {rsp_valid, busy}); end
  endtask

  task automatic test_read();
    int t0;
    r_wait  = 3;
    s_rdata = 32'hDEAD_BEEF;
    set_req(1, 1'b0, 32'h20, 32'h0, 4'h0);
    wait_grant();
    n_tests++; if (req_ready !== 2'b10) begin n_fail++;
      $display("FAIL rd_grant: got %b expected 10", req_ready); end
    t0 = cyc;
    tick();
    req_valid = '0;
    n_tests++; if ({m_axi.arvalid, m_axi.araddr} !== {1'b1, 32'h20}) begin n_fail++;
      $display("FAIL rd_ar: got %b %h expected 1 20", m_axi.arvalid, m_axi.araddr); end
    wait_rsp();
    n_tests++; if (rsp_valid !== 2'b10) begin n_fail++;
      $display("FAIL rd_rsp_valid: got %b expected 10", rsp_valid); end
    n_tests++; if (cyc - t0 !== 6) begin n_fail++;
      $display("FAIL rd_latency: got %0d expected 6", cyc - t0); end
    n_tests++; if ({rsp_rdata, rsp_resp} !== {32'hDEAD_BEEF, 2'b00}) begin n_fail++;
      $display("FAIL rd_rsp_data: got %h/%b expected deadbeef/00", rsp_rdata, rsp_resp); end
    r_wait = 0;
    tick();
  endtask

  task automatic test_round_robin();
    int t_rsp = 0;
    logic [N-1:0] exp_g;
    s_rdata = 32'h1234_5678;
    set_req(0, 1'b1, 32'h100, 32'h1111_1111, 4'hF);
    set_req(1, 1'b0, 32'h200, 32'h0, 4'h0);
    for (int k = 0; k < 6; k++) begin
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      wait_grant();
      n_tests++; if (req_ready !== exp_g) begin n_fail++;
        $display("FAIL rr_grant_%0d: got %b expected %b", k, req_ready, exp_g); end
      if (k > 0) begin
        n_tests++; if (cyc - t_rsp !== 1) begin n_fail++;
          $display("FAIL rr_turnaround_%0d: got %0d expected 1", k, cyc - t_rsp); end
      end
      tick();
      if (k == 5) req_valid = '0;
      wait_rsp();
      t_rsp = cyc;
      n_tests++; if ({rsp_valid, req_ready} !== {exp_g, 2'b00}) begin n_fail++;
        $display("FAIL rr_rsp_%0d: got %b/%b expected %b/00", k, rsp_valid, req_ready, exp_g); end
      n_tests++; if (rsp_rdata !== ((k % 2 == 1) ? 32'h1234_5678 : 32'h0)) begin n_fail++;
        $display("FAIL rr_rdata_%0d: got %h", k, rsp_rdata); end
    end
    tick();
  endtask

  task automatic test_split_handshake();
    logic [9:0] aw_hist, w_hist, b_hist, r_hist;
    aw_wait = 2;
    w_wait  = 5;
    set_req(0, 1'b1, 32'h30, 32'h0BAD_F00D, 4'h3);
    wait_grant();
    n_tests++; if (req_ready !== 2'b01) begin n_fail++;
      $display("FAIL split_grant: got %b expected 01", req_ready); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) req_valid = '0;
      aw_hist[i] = m_axi.awvalid;
      w_hist[i]  = m_axi.wvalid;
      b_hist[i]  = m_axi.bready;
      r_hist[i]  = rsp_valid[0];
    end
    n_tests++; if (aw_hist !== 10'b00_0000_0111) begin n_fail++;
      $display("FAIL split_awvalid: got %b expected 0000000111", aw_hist); end
    n_tests++; if (w_hist !== 10'b00_0011_1111) begin n_fail++;
      $display("FAIL split_wvalid: got %b expected 0000111111", w_hist); end
    n_tests++; if (b_hist !== 10'b00_0100_0000) begin n_fail++;
      $display("FAIL split_bready: got %b expected 0001000000", b_hist); end
    n_tests++; if (r_hist !== 10'b00_1000_0000) begin n_fail++;
      $display("FAIL split_rsp: got %b expected 0010000000", r_hist); end
    aw_wait = 0;
    w_wait  = 0;
  endtask

  task automatic test_error_resp();
    s_rlast = 1'b0;
    s_rdata = 32'hCAFE_0001;
    set_req(1, 1'b0, 32'h44, 32'h0, 4'h0);
    wait_grant();
    tick();
    req_valid = '0;
    wait_rsp();
    n_tests++; if ({rsp_valid, rsp_resp, rsp_rdata} !== {2'b10, 2'b10, 32'hCAFE_0001}) begin n_fail++;
      $display("FAIL rlast_slverr: got %b/%b/%h expected 10/10/cafe0001", rsp_valid, rsp_resp, rsp_rdata); end
    s_rlast = 1'b1;
    tick();
    s_bresp = 2'b11;
    set_req(0, 1'b1, 32'h48, 32'h5, 4'h1);
    wait_grant();
    tick();
    req_valid = '0;
    wait_rsp();
    n_tests++; if ({rsp_valid, rsp_resp, rsp_rdata} !== {2'b01, 2'b11, 32'h0}) begin n_fail++;
      $display("FAIL bresp_decerr: got %b/%b/%h expected 01/11/0", rsp_valid, rsp_resp, rsp_rdata); end
    s_bresp = 2'b00;
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen;
    b_wait = 10;
    set_req(0, 1'b1, 32'h50, 32'h77, 4'hF);
    wait_grant();
    n_tests++; if (req_ready !== 2'b01) begin n_fail++;
      $display("FAIL mid_grant: got %b expected 01", req_ready); end
    tick();
    req_valid = '0;
    for (int i = 0; i < 20 && m_axi.bready !== 1'b1; i++) tick();
    n_tests++; if (m_axi.bready !== 1'b1) begin n_fail++;
      $display("FAIL mid_reach_wr_resp: got %b expected 1", m_axi.bready); end
    areset = 1'b1;
    tick();
    n_tests++; if ({busy, req_ready, rsp_valid, m_axi.awvalid, m_axi.wvalid, m_axi.bready,
                    m_axi.arvalid, m_axi.rready} !== 10'b0) begin n_fail++;
      $display("FAIL mid_reset_outputs: got %b expected 0", {busy, req_ready, rsp_valid,
               m_axi.awvalid, m_axi.wvalid, m_axi.bready, m_axi.arvalid, m_axi.rready}); end
    areset = 1'b0;
    b_wait = 0;
    seen   = 1'b0;
    repeat (12) begin
      tick();
      if (rsp_valid !== '0 || busy !== 1'b0) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++;
      $display("FAIL mid_no_rsp: got %b expected 0", seen); end
    set_req(0, 1'b1, 32'h60, 32'h88, 4'hF);
    set_req(1, 1'b0, 32'h64, 32'h0, 4'h0);
    wait_grant();
    n_tests++; if (req_ready !== 2'b01) begin n_fail++;
      $display("FAIL mid_ptr_restart: got %b expected 01", req_ready); end
    tick();
    req_valid = '0;
    wait_rsp();
    n_tests++; if (rsp_valid !== 2'b01) begin n_fail++;
      $display("FAIL mid_after_rsp: got %b expected 01", rsp_valid); end
    tick();
  endtask

  initial begin
    areset    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wstrb = '0;
    test_reset();
    test_single_write();
    test_read();
    test_round_robin();
    test_split_handshake();
    test_error_resp();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
